exec_wb_unit: RTL and testbench
===============================

Name: exec_wb_unit

Overview:
- Execute/write-back stage directly downstream of the rs1/rs2 operand-routing demux.
- Accepts one decoded operation per handshake: opcode, two 16-bit operands, immediate and destination register.
- Computes the result, single-cycle for all ops except DIV, which is iterative over 16 cycles.
- Presents the result to the register file as a one-cycle write-back pulse.

Parameters:
- N, 16, data width of operands, immediate and result.
- SEL, 4, opcode width.
- RA, 4, register address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  unit can accept an operation this cycle.
- op_opcode  input  SEL  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 LI, 8-15 illegal.
- rs1_val  input  N  first operand.
- rs2_val  input  N  second operand.
- imm  input  N  immediate, used by LI only.
- rd_addr  input  RA  destination register.
- wb_valid  output  1  one-cycle write-back strobe.
- wb_rd  output  RA  destination of the write-back.
- wb_data  output  N  result.
- wb_illegal  output  1  qualifies wb_valid; the op was illegal and wb_data=0.
- div_by_zero  output  1  qualifies wb_valid; DIV with rs2_val=0.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=1; wb_valid=0; wb_rd=0; wb_data=0; wb_illegal=0; div_by_zero=0; divider cleared.
  - Reset wins over every other event, including a DIV in flight, which is discarded with no write-back.
- Handshake: an op is accepted on a clock edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && !rst.
  - All inputs are sampled only at acceptance; upstream may change them afterwards.
  - There is no write-back backpressure: the register file always accepts.
- States:
  - IDLE: accept an op.
    - Opcode != 3: compute combinationally and register the result. wb_valid=1 in the next cycle (latency 1). Stay in IDLE, so back-to-back ops give one result per cycle.
    - Opcode == 3, rs2_val != 0: latch the operands and rd, counter=15, go to DIV.
    - Opcode == 3, rs2_val == 0: no iteration. Next cycle wb_valid=1, wb_data=16'hFFFF, div_by_zero=1. Stay in IDLE.
  - DIV: one restoring-division step per cycle, quotient MSB first. counter decrements each cycle. When counter==0 the step completes and the state goes to DONE.
  - DONE: wb_valid=1 with quotient and rd. in_ready=0 during this cycle. Next state IDLE.
  - DIV total latency: accepted at edge T, wb_valid high in cycle T+17. in_ready is low from T+1 through T+17.
- Arithmetic: all results are truncated to N bits, unsigned.
  - ADD and SUB wrap modulo 2^N (FFFF+1=0; 0-1=FFFF).
  - MUL returns the low N bits of the product.
  - DIV returns the unsigned quotient; the remainder is discarded.
  - AND, OR, XOR are bitwise.
  - LI returns imm; rs1_val and rs2_val are ignored.
- Illegal opcode (8-15): next cycle wb_valid=1, wb_illegal=1, wb_data=0, wb_rd=rd_addr.
- Flag timing:
  - wb_valid is a single-cycle pulse per accepted op; it is never held.
  - wb_illegal and div_by_zero are 0 whenever wb_valid=0.
  - wb_data and wb_rd hold their last values when wb_valid=0.
- in_valid while in_ready=0 is ignored; the op is not lost because upstream holds it until accepted.

Decomposition:
- Shared package cpu_pkg:
  - opcode_e enum (OP_ADD=0 .. OP_LI=7).
  - Constants N_W=16, SEL_W=4, RA_W=4.
  - DIV_BY_ZERO_Q=16'hFFFF.
- One sub-module: div_iter16, an iterative restoring divider.
  - Ports: clk, rst, start, dividend, divisor, busy, done, quotient.
  - It is instantiated once; the remaining ops stay inline.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=1 -> in_ready=0 and wb_valid=0 throughout; after release in_ready=1 and all outputs are 0.
- Back-to-back single-cycle ops:
  - Send ADD (7,5,rd=1), SUB (0,1,rd=2), MUL (300,300,rd=3), LI (imm=16'h1234,rd=4) on consecutive cycles.
  - Required: four consecutive wb_valid pulses with data 12, FFFF, 0x5F90, 0x1234 and rd 1..4.
- Division:
  - DIV 1000/7, rd=5 -> in_ready low for 17 cycles; wb_valid 17 cycles after acceptance with data 142, rd 5.
  - An ADD presented during the DIV is accepted only after DONE.
- Divide by zero: DIV 9/0 -> wb_valid next cycle, wb_data=FFFF, div_by_zero=1, wb_illegal=0.
- Illegal and logic ops:
  - Opcode 12 -> wb_illegal=1, wb_data=0.
  - AND/OR/XOR of F0F0 with 0FF0 -> 00F0, FFF0, FF00.
- Reset mid-DIV: assert rst 5 cycles after accepting DIV 500/3 -> no wb_valid at any time; the next op after reset completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the execute/write-back slice: data, opcode and
// register-address widths, the opcode encoding, the FSM state encoding of the
// execute unit, and the quotient returned for a division by zero.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int N_W   = 16;
    localparam int SEL_W = 4;
    localparam int RA_W  = 4;

    // An all-ones quotient matches what an unsigned restoring divider
    // converges to when the divisor is zero.
    localparam logic [N_W-1:0] DIV_BY_ZERO_Q = 16'hFFFF;

    // Legal opcodes occupy 0..7. Anything with the top bit set is illegal.
    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_LI  = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_iter16.sv
// ---------------------------------------------------------------------------
// div_iter16
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// A division takes N steps after the start edge.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, abandons any division in flight
//   start    load dividend/divisor and begin (ignored while busy)
//   dividend numerator, sampled on start
//   divisor  denominator, sampled on start; must be non-zero
//   busy     a division is in progress
//   done     high during the final step; quotient is valid in that cycle
//   quotient quotient including the bit produced by the current step
// ---------------------------------------------------------------------------
module div_iter16
    import cpu_pkg::*;
#(
    parameter int N = N_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_divisor;
    logic [CW-1:0] r_count;
    logic          r_busy;

    logic [N:0]    w_trial;
    logic [N:0]    w_diff;
    logic          w_ge;
    logic [N-1:0]  w_remNext;
    logic [N-1:0]  w_quotNext;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. Because the remainder always stays
    // below the divisor, the trial value is below twice the divisor, so the
    // top bit of the difference is a clean borrow / "does not fit" flag.
    always_comb begin
        w_trial    = {r_rem, r_quot[N-1]};
        w_diff     = w_trial - {1'b0, r_divisor};
        w_ge       = ~w_diff[N];
        w_remNext  = w_ge ? w_diff[N-1:0] : w_trial[N-1:0];
        w_quotNext = {r_quot[N-2:0], w_ge};
    end

    // r_quot doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else if (r_busy) begin
            r_rem   <= w_remNext;
            r_quot  <= w_quotNext;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
                r_busy <= 1'b0;
            end
        end else if (start) begin
            r_rem     <= '0;
            r_quot    <= dividend;
            r_divisor <= divisor;
            r_count   <= CW'(N - 1);
            r_busy    <= 1'b1;
        end
    end

    assign busy     = r_busy;
    assign done     = r_busy && (r_count == '0);
    assign quotient = w_quotNext;

endmodule

// File: rtl/exec_wb_unit.sv
// ---------------------------------------------------------------------------
// exec_wb_unit
// Execute/write-back stage. Accepts one decoded op per valid/ready handshake,
// computes the result and emits it to the register file as a single-cycle
// write-back pulse. All ops take one cycle except a DIV with a non-zero
// divisor, which runs through the iterative divider and blocks new ops until
// its result has been written back.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     upstream presents an op
//   in_ready     unit accepts an op this cycle
//   op_opcode    0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 LI, 8+ illegal
//   rs1_val      first operand
//   rs2_val      second operand
//   imm          immediate for LI
//   rd_addr      destination register
//   wb_valid     one-cycle write-back strobe
//   wb_rd        destination of the write-back (holds when idle)
//   wb_data      write-back value (holds when idle)
//   wb_illegal   with wb_valid: op was illegal, wb_data is 0
//   div_by_zero  with wb_valid: DIV with zero divisor, wb_data is all ones
// ---------------------------------------------------------------------------
module exec_wb_unit
    import cpu_pkg::*;
#(
    parameter int N   = N_W,
    parameter int SEL = SEL_W,
    parameter int RA  = RA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SEL-1:0] op_opcode,
    input  logic [N-1:0]   rs1_val,
    input  logic [N-1:0]   rs2_val,
    input  logic [N-1:0]   imm,
    input  logic [RA-1:0]  rd_addr,
    output logic           wb_valid,
    output logic [RA-1:0]  wb_rd,
    output logic [N-1:0]   wb_data,
    output logic           wb_illegal,
    output logic           div_by_zero
);

    state_e        r_state;
    state_e        w_stateNext;

    logic          r_wbValid;
    logic [RA-1:0] r_wbRd;
    logic [N-1:0]  r_wbData;
    logic          r_wbIllegal;
    logic          r_divByZero;
    logic [RA-1:0] r_divRd;

    logic          w_inReady;
    logic          w_accept;
    logic          w_isDiv;
    logic          w_divStart;
    logic          w_divZero;
    logic [N-1:0]  w_aluResult;
    logic          w_illegal;

    logic          w_divBusy;
    logic          w_divDone;
    logic [N-1:0]  w_divQuot;

    // Handshake qualifiers and DIV routing.
    always_comb begin
        w_accept   = in_valid && w_inReady;
        w_isDiv    = (op_opcode == OP_DIV);
        w_divStart = w_accept && w_isDiv && (rs2_val != '0);
        w_divZero  = w_accept && w_isDiv && (rs2_val == '0);
    end

    // Single-cycle ALU. DIV is produced elsewhere, so its slot here is a
    // don't-care zero; any opcode outside 0..7 is flagged illegal.
    always_comb begin
        w_aluResult = '0;
        w_illegal   = 1'b0;
        case (op_opcode)
            OP_ADD:  w_aluResult = rs1_val + rs2_val;
            OP_SUB:  w_aluResult = rs1_val - rs2_val;
            OP_MUL:  w_aluResult = rs1_val * rs2_val;
            OP_DIV:  w_aluResult = '0;
            OP_AND:  w_aluResult = rs1_val & rs2_val;
            OP_OR:   w_aluResult = rs1_val | rs2_val;
            OP_XOR:  w_aluResult = rs1_val ^ rs2_val;
            OP_LI:   w_aluResult = imm;
            default: w_illegal   = 1'b1;
        endcase
    end

    div_iter16 #(
        .N(N)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (w_divStart),
        .dividend(rs1_val),
        .divisor (rs2_val),
        .busy    (w_divBusy),
        .done    (w_divDone),
        .quotient(w_divQuot)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. The DIV state ends on the divider's final step, so
    // DONE coincides with the cycle the quotient is written back.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (w_divStart) w_stateNext = ST_DIV;
            ST_DIV:  if (w_divDone)  w_stateNext = ST_DONE;
            ST_DONE: w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Output logic. Ready drops combinationally with reset so nothing is
    // accepted on a reset edge.
    always_comb begin
        w_inReady = (r_state == ST_IDLE) && !rst;
    end

    // Write-back registers. The strobe and its qualifiers are pulses that
    // clear every cycle; data and rd only change when a result is produced.
    // r_wbIllegal is unused in the DIV paths because illegal opcodes never
    // reach the divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbValid   <= 1'b0;
            r_wbRd      <= '0;
            r_wbData    <= '0;
            r_wbIllegal <= 1'b0;
            r_divByZero <= 1'b0;
            r_divRd     <= '0;
        end else begin
            r_wbValid   <= 1'b0;
            r_wbIllegal <= 1'b0;
            r_divByZero <= 1'b0;
            if (w_accept && !w_isDiv) begin
                r_wbValid   <= 1'b1;
                r_wbRd      <= rd_addr;
                r_wbData    <= w_aluResult;
                r_wbIllegal <= w_illegal;
            end
            if (w_divZero) begin
                r_wbValid   <= 1'b1;
                r_wbRd      <= rd_addr;
                r_wbData    <= N'(DIV_BY_ZERO_Q);
                r_divByZero <= 1'b1;
            end
            if (w_divStart) begin
                r_divRd <= rd_addr;
            end
            if ((r_state == ST_DIV) && w_divDone) begin
                r_wbValid <= 1'b1;
                r_wbRd    <= r_divRd;
                r_wbData  <= w_divQuot;
            end
        end
    end

    assign in_ready    = w_inReady;
    assign wb_valid    = r_wbValid;
    assign wb_rd       = r_wbRd;
    assign wb_data     = r_wbData;
    assign wb_illegal  = r_wbIllegal;
    assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_exec_wb_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_wb_unit
// Directed bench for exec_wb_unit: reset behaviour, a back-to-back table of
// single-cycle ops with hand-computed results, then hand-written sequences
// for the iterative divide, an op held during a divide, and reset mid-divide.
// ---------------------------------------------------------------------------
module tb_exec_wb_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_opcode;
    logic [15:0] rs1_val;
    logic [15:0] rs2_val;
    logic [15:0] imm;
    logic [3:0]  rd_addr;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        wb_illegal;
    logic        div_by_zero;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [3:0]  opcode;
        logic [15:0] rs1;
        logic [15:0] rs2;
        logic [15:0] imm;
        logic [3:0]  rd;
        logic [15:0] expData;
        logic        expIllegal;
        logic        expDz;
    } vec_t;

    vec_t vecs[11];

    exec_wb_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_opcode  (op_opcode),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .imm        (imm),
        .rd_addr    (rd_addr),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_illegal (wb_illegal),
        .div_by_zero(div_by_zero)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] im, input logic [3:0] rd);
        in_valid  = v;
        op_opcode = op;
        rs1_val   = a;
        rs2_val   = b;
        imm       = im;
        rd_addr   = rd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWb(input string tag, input logic [3:0] rd,
                           input logic [15:0] data, input logic ill, input logic dz);
        checkOutput({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
        checkOutput({tag, " wb_data"}, 32'(wb_data), 32'(data));
        checkOutput({tag, " wb_illegal"}, 32'(wb_illegal), 32'(ill));
        checkOutput({tag, " div_by_zero"}, 32'(div_by_zero), 32'(dz));
    endtask

    initial begin
        int cycles;
        int badReady;
        int badValid;
        int seenValid;

        // Back-to-back single-cycle table, with expected results worked out by hand.
        vecs[0]  = '{4'd0, 16'd7,     16'd5,     16'h0000, 4'd1,  16'd12,    1'b0, 1'b0};
        vecs[1]  = '{4'd1, 16'd0,     16'd1,     16'h0000, 4'd2,  16'hFFFF,  1'b0, 1'b0};
        vecs[2]  = '{4'd2, 16'd300,   16'd300,   16'h0000, 4'd3,  16'h5F90,  1'b0, 1'b0};
        vecs[3]  = '{4'd7, 16'hAAAA,  16'h5555,  16'h1234, 4'd4,  16'h1234,  1'b0, 1'b0};
        vecs[4]  = '{4'd0, 16'hFFFF,  16'd1,     16'h0000, 4'd11, 16'h0000,  1'b0, 1'b0};
        vecs[5]  = '{4'd3, 16'd9,     16'd0,     16'h0000, 4'd10, 16'hFFFF,  1'b0, 1'b1};
        vecs[6]  = '{4'd12, 16'h1111, 16'h2222,  16'h3333, 4'd9,  16'h0000,  1'b1, 1'b0};
        vecs[7]  = '{4'd4, 16'hF0F0,  16'h0FF0,  16'h0000, 4'd6,  16'h00F0,  1'b0, 1'b0};
        vecs[8]  = '{4'd5, 16'hF0F0,  16'h0FF0,  16'h0000, 4'd7,  16'hFFF0,  1'b0, 1'b0};
        vecs[9]  = '{4'd15, 16'hFFFF, 16'hFFFF,  16'hFFFF, 4'd15, 16'h0000,  1'b1, 1'b0};
        vecs[10] = '{4'd6, 16'hF0F0,  16'h0FF0,  16'h0000, 4'd8,  16'hFF00,  1'b0, 1'b0};

        // Reset held for two edges with an op presented: nothing accepted.
        rst = 1'b1;
        applyStimulus(1'b1, 4'd0, 16'd1, 16'd2, 16'd0, 4'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("reset in_ready", 32'(in_ready), 32'd0);
            checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        #1;
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("post-reset wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("post-reset wb_data", 32'(wb_data), 32'd0);
        checkOutput("post-reset wb_illegal", 32'(wb_illegal), 32'd0);
        checkOutput("post-reset div_by_zero", 32'(div_by_zero), 32'd0);

        // Table: one op per cycle, each result appears one cycle later.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].opcode, vecs[i].rs1, vecs[i].rs2,
                          vecs[i].imm, vecs[i].rd);
            step();
            checkWb($sformatf("vec%0d", i), vecs[i].rd, vecs[i].expData,
                    vecs[i].expIllegal, vecs[i].expDz);
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        step();
        checkOutput("idle wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("idle hold wb_data", 32'(wb_data), 32'hFF00);
        checkOutput("idle hold wb_rd", 32'(wb_rd), 32'd8);
        checkOutput("idle wb_illegal", 32'(wb_illegal), 32'd0);

        // DIV 1000/7 with an ADD held behind it.
        applyStimulus(1'b1, 4'd3, 16'd1000, 16'd7, 16'd0, 4'd5);
        step();
        applyStimulus(1'b1, 4'd0, 16'd2, 16'd3, 16'd0, 4'd12);
        cycles   = 1;
        badReady = 0;
        while (!wb_valid && cycles < 40) begin
            if (in_ready !== 1'b0) badReady++;
            step();
            cycles++;
        end
        checkOutput("div latency", 32'(cycles), 32'd17);
        checkWb("div 1000/7", 4'd5, 16'd142, 1'b0, 1'b0);
        checkOutput("div in_ready low while busy", 32'(badReady), 32'd0);
        checkOutput("div in_ready low at done", 32'(in_ready), 32'd0);
        step();
        checkOutput("after done wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("after done in_ready", 32'(in_ready), 32'd1);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        checkWb("held add", 4'd12, 16'd5, 1'b0, 1'b0);

        // Reset five cycles into DIV 500/3: the divide produces nothing.
        applyStimulus(1'b1, 4'd3, 16'd500, 16'd3, 16'd0, 4'd13);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        badValid = 0;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid !== 1'b0) badValid++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (wb_valid !== 1'b0) badValid++;
            step();
        end
        checkOutput("reset mid-div no wb", 32'(badValid), 32'd0);
        checkOutput("reset mid-div in_ready", 32'(in_ready), 32'd1);

        // First op after the aborted divide completes normally.
        applyStimulus(1'b1, 4'd0, 16'd10, 16'd20, 16'd0, 4'd14);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        checkWb("add after reset", 4'd14, 16'd30, 1'b0, 1'b0);

        // A fresh divide after the abort starts from a clean divider.
        applyStimulus(1'b1, 4'd3, 16'd500, 16'd3, 16'd0, 4'd15);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 4'd0);
        cycles    = 1;
        seenValid = 0;
        while (!wb_valid && cycles < 40) begin
            step();
            cycles++;
        end
        if (wb_valid) seenValid = 1;
        checkOutput("div 500/3 completes", 32'(seenValid), 32'd1);
        checkOutput("div 500/3 latency", 32'(cycles), 32'd17);
        checkWb("div 500/3", 4'd15, 16'd166, 1'b0, 1'b0);
        step();
        checkOutput("div pulse single", 32'(wb_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
